rgb_pwm: RTL
============

# rgb_pwm

Three-channel PWM generator for the RGB LED, directly downstream of the 4-bit clock divider. It consumes the divider's toggling output as a time base, runs a shared PWM period counter, and drives the red, green and blue LED pins from per-channel duty values. New duty values arrive over a valid/ready handshake and are applied only at a period boundary, so the LED never shows a glitched partial period.

## Interface
- WIDTH, 8, duty and period-counter width; period = 2^WIDTH-1 ticks
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- div_clk  in  1  toggling output of the clock divider, in the clk domain; each rising edge is one PWM tick
- duty_r  in  WIDTH  red duty request
- duty_g  in  WIDTH  green duty request
- duty_b  in  WIDTH  blue duty request
- duty_valid  in  1  duty_r/g/b hold a new request
- duty_ready  out  1  pending slot empty; transfer occurs when duty_valid && duty_ready
- led_r  out  1  red PWM output, active-high
- led_g  out  1  green PWM output, active-high
- led_b  out  1  blue PWM output, active-high
- period_start  out  1  one-clk pulse when the counter wraps to 0

## Operation
- Tick detect: register div_clk into div_q; tick = div_clk & ~div_q. A tick is one clk cycle wide. The divider toggles every 10 clk, so a tick occurs every 20 clk.
- Counter: cnt is WIDTH bits and advances only on a tick.
  - Counting runs 0..MAX-1, where MAX = 2^WIDTH-1.
  - On a tick with cnt == MAX-1, cnt returns to 0 (wrap).
  - Sequence for WIDTH=8: 0..254, 255 ticks per period.
- Channel output: led_x <= (cnt < active_x).
  - Duty 0 gives the output permanently low.
  - Duty MAX gives the output permanently high.
  - Duty d gives exactly d high ticks per period.
- Handshake:
  - pending_full flag; duty_ready = ~pending_full.
  - On transfer, the three duties are latched into pending_x and pending_full is set.
  - duty_valid while duty_ready is low is ignored; no state changes.
- Commit: on the wrap tick with pending_full set, active_x <= pending_x and pending_full is cleared. duty_ready returns high the next cycle.
- Simultaneous events: a transfer in the same cycle as a wrap tick (pending empty) is not committed at that wrap. It is committed at the following wrap.
- Reset: asynchronous and immediate. No commit or transfer completes across reset.

## Timing
- Reset values:
  - cnt = 0, active_x = 0, pending_x = 0, pending_full = 0, div_q = 0
  - led_r/g/b = 0, period_start = 0, duty_ready = 1
- Tick latency: counter update occurs 1 clk after the div_clk rising edge is sampled (edge-detect register).
- Output latency: led_x is registered, 1 clk after the cnt/active change.
- period_start is registered and asserts in the clk cycle after cnt becomes 0.
- Request-to-effect latency: worst case one full period plus 2 clk.
- duty_ready falls the clk after a transfer.

## Configuration
- RGB_PWM_FADE_EN defined:
  - At each wrap, every active_x steps by ±1 toward its committed target_x; a channel already equal to its target holds.
  - Commit loads target_x instead of active_x.
  - A 0→255 fade takes 255 periods.
- RGB_PWM_FADE_EN undefined:
  - No target_x registers.
  - Commit loads active_x directly (jump).

## Structure
- Package rgb_pwm_pkg holds:
  - Parameter default WIDTH.
  - Constant PWM_MAX = 2^WIDTH-1.
  - typedef rgb_duty_t, a struct of three WIDTH-bit fields (r, g, b), used for pending, active and target.
- One sub-module, pwm_channel, instantiated three times. It holds active (and target under FADE), takes the shared cnt and wrap strobe, and produces one registered LED bit.
- The top holds the edge detect, counter and handshake.

## Test plan
- Reset: hold rst_n=0 with div_clk toggling every 10 clk -> all LEDs 0, duty_ready 1, no period_start.
- Duty request (0x80,0x00,0xFF) accepted after reset -> from the first wrap: led_r high 128 of 255 ticks, led_g never high, led_b always high; period_start every 5100 clk.
- Backpressure: second request while pending_full -> duty_ready=0, second value ignored. A third request accepted after the wrap commits at the next wrap.
- Transfer on the exact wrap tick -> value not applied until the following period_start.
- Async reset mid-period (cnt≈100, pending_full=1) -> outputs 0 immediately, pending discarded, duty_ready=1.
- FADE_EN: request r=5 from r=0 -> led_r high count per period is 1,2,3,4,5,5.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared width, PWM ceiling and per-colour duty record for rgb_pwm
package rgb_pwm_pkg;

  localparam int PWM_WIDTH = 8;
  localparam int PWM_MAX   = (1 << PWM_WIDTH) - 1;

  typedef struct packed {
    logic [PWM_WIDTH-1:0] r;
    logic [PWM_WIDTH-1:0] g;
    logic [PWM_WIDTH-1:0] b;
  } rgb_duty_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// rtl/rgb_pwm_channel.sv - one colour of rgb_pwm: active duty (target when RGB_PWM_FADE_EN) and registered LED bit
// RGB_PWM_FADE_EN: active walks one step per wrap toward a committed target instead of jumping.
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_wrap,
  input  logic             i_commit,
  input  logic [WIDTH-1:0] i_duty,
  output logic             o_led
);

  logic [WIDTH-1:0] r_active;
  logic             r_led;

`ifdef RGB_PWM_FADE_EN
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] w_target_next;

  // A commit on this wrap already steers the step taken on the same wrap.
  assign w_target_next = i_commit ? i_duty : r_target;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target <= '0;
      r_active <= '0;
    end else begin
      if (i_commit) begin
        r_target <= i_duty;
      end
      if (i_wrap) begin
        if (r_active < w_target_next) begin
          r_active <= r_active + 1'b1;
        end else if (r_active > w_target_next) begin
          r_active <= r_active - 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= '0;
    end else if (i_commit) begin
      r_active <= i_duty;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= (i_cnt < r_active);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - three-channel LED PWM timed by the divider output; duty updates land only on period wrap
// RGB_PWM_FADE_EN (see pwm_channel) switches channels from jump to one-step-per-period fading.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk,
  input  logic [WIDTH-1:0] duty_r,
  input  logic [WIDTH-1:0] duty_g,
  input  logic [WIDTH-1:0] duty_b,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             period_start
);

  // The counter's last value is MAX-1, so a period is 2^WIDTH-1 ticks and duty MAX is solid on.
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

  logic             r_div_q;
  logic [WIDTH-1:0] r_cnt;
  rgb_duty_t        r_pending;
  logic             r_pending_full;
  logic             r_period_start;

  logic w_tick;
  logic w_wrap;
  logic w_xfer;
  logic w_commit;

  assign w_tick     = div_clk & ~r_div_q;
  assign w_wrap     = w_tick && (r_cnt == CNT_LAST);
  assign w_xfer     = duty_valid && !r_pending_full;
  assign w_commit   = w_wrap && r_pending_full;
  assign duty_ready = ~r_pending_full;
  assign period_start = r_period_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q        <= 1'b0;
      r_cnt          <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_div_q        <= div_clk;
      r_period_start <= w_wrap;
      if (w_tick) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
      // Transfer needs an empty slot and commit needs a full one, so they never coincide.
      if (w_xfer) begin
        r_pending      <= '{r: duty_r, g: duty_g, b: duty_b};
        r_pending_full <= 1'b1;
      end else if (w_commit) begin
        r_pending_full <= 1'b0;
      end
    end
  end

  pwm_channel #(.WIDTH(WIDTH)) u_ch_r (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_cnt    (r_cnt),
    .i_wrap   (w_wrap),
    .i_commit (w_commit),
    .i_duty   (r_pending.r),
    .o_led    (led_r)
  );

  pwm_channel #(.WIDTH(WIDTH)) u_ch_g (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_cnt    (r_cnt),
    .i_wrap   (w_wrap),
    .i_commit (w_commit),
    .i_duty   (r_pending.g),
    .o_led    (led_g)
  );

  pwm_channel #(.WIDTH(WIDTH)) u_ch_b (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_cnt    (r_cnt),
    .i_wrap   (w_wrap),
    .i_commit (w_commit),
    .i_duty   (r_pending.b),
    .o_led    (led_b)
  );

endmodule
